// File: rtl/uart_transmitter.sv
// Sends a 32-bit word as four UART frames, byte 0 first and each byte LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after each byte's data bits.
`timescale 1ns/1ps
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        TxD_start,
    input  logic [31:0] dataIn,
    output logic        dataOver,
    output logic [31:0] dataOut,
    output logic        txd,
    output logic        busy
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_shift;
    logic [31:0]       r_word;
    logic [31:0]       r_data_out;
    logic              r_txd;

    logic [2:0]        w_state_d;
    logic [BAUD_W-1:0] w_baud_d;
    logic [2:0]        w_bit_d;
    logic [1:0]        w_byte_d;
    logic [31:0]       w_shift_d;
    logic [31:0]       w_word_d;
    logic [31:0]       w_data_out_d;
    logic              w_txd_d;
    logic              w_baud_last;

`ifdef UART_TX_PARITY_EN
    logic              r_parity;
    logic              w_parity_d;
`endif

    assign w_baud_last = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_d    = r_state;
        w_baud_d     = r_baud;
        w_bit_d      = r_bit_idx;
        w_byte_d     = r_byte_idx;
        w_shift_d    = r_shift;
        w_word_d     = r_word;
        w_data_out_d = r_data_out;
`ifdef UART_TX_PARITY_EN
        w_parity_d   = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (TxD_start) begin
                    w_shift_d = dataIn;
                    w_word_d  = dataIn;
                    w_byte_d  = 2'd0;
                    w_bit_d   = 3'd0;
                    w_baud_d  = '0;
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                w_baud_d = w_baud_last ? '0 : r_baud + 1'b1;
                if (w_baud_last) begin
                    w_state_d  = ST_DATA;
                    w_bit_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
                    w_parity_d = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                w_baud_d = w_baud_last ? '0 : r_baud + 1'b1;
                if (w_baud_last) begin
                    // The word shifts continuously, so the next byte lines up at bit 0.
                    w_shift_d  = {1'b0, r_shift[31:1]};
`ifdef UART_TX_PARITY_EN
                    w_parity_d = r_parity ^ r_shift[0];
`endif
                    if (r_bit_idx == 3'd7) begin
                        w_bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state_d = ST_PARITY;
`else
                        w_state_d = ST_STOP;
`endif
                    end else begin
                        w_bit_d = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_baud_d = w_baud_last ? '0 : r_baud + 1'b1;
                if (w_baud_last) begin
                    w_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                w_baud_d = w_baud_last ? '0 : r_baud + 1'b1;
                if (w_baud_last) begin
                    if (r_byte_idx == 2'd3) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_byte_d  = r_byte_idx + 2'd1;
                        w_state_d = ST_START;
                    end
                end
            end
            ST_DONE: begin
                w_data_out_d = r_word;
                w_state_d    = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so the pin never glitches.
    always_comb begin
        case (w_state_d)
            ST_START:  w_txd_d = 1'b0;
            ST_DATA:   w_txd_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_d = w_parity_d;
`endif
            default:   w_txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 32'd0;
            r_word     <= 32'd0;
            r_data_out <= 32'd0;
            r_txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_baud     <= w_baud_d;
            r_bit_idx  <= w_bit_d;
            r_byte_idx <= w_byte_d;
            r_shift    <= w_shift_d;
            r_word     <= w_word_d;
            r_data_out <= w_data_out_d;
            r_txd      <= w_txd_d;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_d;
`endif
        end
    end

    assign txd      = r_txd;
    assign busy     = (r_state != ST_IDLE);
    assign dataOver = (r_state == ST_DONE);
    assign dataOut  = r_data_out;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised bench for uart_transmitter: a cycle-indexed line model plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB     = 11;
    localparam int L_DONE = 177;
    localparam int L_GAP  = 178;
`else
    localparam int FB     = 10;
    localparam int L_DONE = 161;
    localparam int L_GAP  = 162;
`endif
    localparam int WT = 4 * FB * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din = 32'd0;
    logic        data_over;
    logic [31:0] data_out;
    logic        txd;
    logic        busy;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .TxD_start (start),
        .dataIn    (din),
        .dataOver  (data_over),
        .dataOut   (data_out),
        .txd       (txd),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_prints = 0;
    int cyc_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_prints < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            n_prints++;
        end
    endtask

    // Expected line level k cycles into a word (k=1 is the first start-bit cycle).
    function automatic logic exp_bit(input logic [31:0] w, input int k);
        int b, f, p;
        if (k > WT) return 1'b1;
        b = (k - 1) / C;
        f = b / FB;
        p = b % FB;
        if (p == 0) return 1'b0;
        if (p <= 8) return w[f*8 + p - 1];
`ifdef UART_TX_PARITY_EN
        if (p == 9) return ^w[f*8 +: 8];
`endif
        return 1'b1;
    endfunction

    logic        m_valid = 1'b0;
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic [31:0] m_word = 32'd0;
    logic [31:0] m_out = 32'd0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_k      <= 0;
            m_out    <= 32'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_word   <= din;
                m_k      <= 1;
            end
        end else if (m_k == WT + 1) begin
            m_active <= 1'b0;
            m_out    <= m_word;
            m_k      <= 0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("txd", {31'd0, txd}, {31'd0, m_active ? exp_bit(m_word, m_k) : 1'b1});
            check("busy", {31'd0, busy}, {31'd0, m_active});
            check("dataOver", {31'd0, data_over}, {31'd0, m_active && (m_k == WT + 1)});
            check("dataOut", data_out, m_out);
        end
    end

    task automatic wait_pulse(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            if (data_over) begin
                t = cyc_cnt;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pulse_timeout: got none expected dataOver within %0d cycles", bound);
        end
    endtask

    task automatic pulse_start(input logic [31:0] w);
        din   = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic samp [0:1023];
    logic [7:0] lit_bytes [0:3];

    initial begin
        int t0, t1, t2, cyc, pulses;
        logic [31:0] w;
        logic [7:0] rx;

        // Reset, with a start request held during it.
        rst = 1'b1;
        start = 1'b1;
        din = $urandom;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_over", {31'd0, data_over}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        repeat (2) @(negedge clk);

        // Single word, with dataIn changed right after capture.
        lit_bytes[0] = 8'h12; lit_bytes[1] = 8'h0F; lit_bytes[2] = 8'hC3; lit_bytes[3] = 8'hA5;
        pulse_start(32'hA5C30F12);
        din = $urandom;
        cyc = 1;
        samp[1] = txd;
        while (!data_over && cyc < 400) begin
            @(negedge clk);
            cyc++;
            samp[cyc] = txd;
        end
        check("single_latency", cyc, L_DONE);
        for (int j = 0; j < 4; j++) begin
            check("rx_start", {31'd0, samp[(j*FB)*C + C/2 + 1]}, 32'd0);
            rx = 8'd0;
            for (int i = 0; i < 8; i++) rx[i] = samp[(j*FB + 1 + i)*C + C/2 + 1];
            check("rx_byte", {24'd0, rx}, {24'd0, lit_bytes[j]});
`ifdef UART_TX_PARITY_EN
            check("rx_parity", {31'd0, samp[(j*FB + 9)*C + C/2 + 1]}, {31'd0, ^lit_bytes[j]});
`endif
            check("rx_stop", {31'd0, samp[(j*FB + FB - 1)*C + C/2 + 1]}, 32'd1);
        end
        @(negedge clk);
        check("single_dout", data_out, 32'hA5C30F12);
        check("single_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back with start held high.
        din = $urandom;
        start = 1'b1;
        repeat (20) @(negedge clk);
        din = 32'h0000_0001;
        wait_pulse(400, t1);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_pulse(400, t2);
        check("b2b_gap", t2 - t1, L_GAP);
        @(negedge clk);
        check("b2b_dout", data_out, 32'h0000_0001);
        repeat (3) @(negedge clk);

        // Start pulses while busy are dropped.
        pulse_start($urandom);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(3, 12)) @(negedge clk);
            din = $urandom;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            if (data_over) pulses++;
            @(negedge clk);
        end
        check("busy_pulses", pulses, 32'd1);

        // Reset during byte 2.
        pulse_start($urandom);
        repeat (2*FB*C + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_dout", data_out, 32'd0);
        w = $urandom;
        pulse_start(w);
        t0 = cyc_cnt;
        wait_pulse(400, t1);
        check("fresh_latency", t1 - t0 + 1, L_DONE);
        @(negedge clk);
        check("fresh_dout", data_out, w);

        // Randomised traffic, occasional mid-word reset.
        for (int n = 0; n < 25; n++) begin
            w = $urandom;
            din = w;
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            din = $urandom;
            if (n % 8 == 5) begin
                repeat ($urandom_range(1, WT - 10)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                wait_pulse(400, t1);
                @(negedge clk);
                check("rand_dout", data_out, w);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
